// File: rtl/gdsp_pkg.sv
// Shared definitions for the 16-QAM TX/RX debug chain: sample type,
// symbol geometry, Gray code points and the default slicer threshold.
`timescale 1ns/1ps
package gdsp_pkg;

  localparam int SAMPLE_W     = 12;
  localparam int BITS_PER_SYM = 4;
  localparam int SPS          = 4;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Per-axis Gray code for the four amplitude levels, shared with the mapper.
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  // Midpoint between the +1 and +3 levels for a unit level of 256.
  localparam sample_t QAM_THRESH_DEF = 12'sd512;

  // Amplitude level index on one axis, ordered from most negative upward.
  typedef enum logic [1:0] {
    LVL_M3 = 2'd0,
    LVL_M1 = 2'd1,
    LVL_P1 = 2'd2,
    LVL_P3 = 2'd3
  } level_e;

  function automatic logic [1:0] level_to_gray(input level_e lvl);
    logic [1:0] g;
    unique case (lvl)
      LVL_M3:  g = GRAY_M3;
      LVL_M1:  g = GRAY_M1;
      LVL_P1:  g = GRAY_P1;
      default: g = GRAY_P3;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data, full/empty flags and
// simultaneous push/pop (a pop on a full FIFO frees the slot for the push).
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; occupancy is tracked by the
  // pointers, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/qam16_demapper.sv
// 16-QAM receive demapper: decimates channel samples at a chosen phase,
// hard-slices and Gray-decodes each symbol, and keeps bit-error statistics
// against a buffered copy of the transmitted bits.
`timescale 1ns/1ps
module qam16_demapper #(
  parameter  int SPS         = gdsp_pkg::SPS,
  parameter  int REF_DEPTH   = 32,
  parameter  int WARMUP_SYMS = 16,
  parameter  int CNT_W       = 32,
  localparam int PH_W        = (SPS > 1) ? $clog2(SPS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  gdsp_pkg::sample_t                   rx_I,
  input  gdsp_pkg::sample_t                   rx_Q,
  input  logic [PH_W-1:0]                     sym_phase,
  input  gdsp_pkg::sample_t                   thresh,
  input  logic [gdsp_pkg::BITS_PER_SYM-1:0]   ref_bits,
  input  logic                                ref_valid,
  input  logic                                clr_stats,
  output logic [gdsp_pkg::BITS_PER_SYM-1:0]   bits_out,
  output logic                                valid,
  output logic [CNT_W-1:0]                    bit_err_cnt,
  output logic [CNT_W-1:0]                    sym_cnt,
  output logic                                ref_ovf,
  output logic                                ref_unf
);

  import gdsp_pkg::*;

  localparam int WARM_W = $clog2(WARMUP_SYMS + 2);
  localparam int PC_W   = $clog2(BITS_PER_SYM + 1);

  // Four-way decision on one axis; -thresh and 0 belong to the upper bin.
  function automatic level_e slice_axis(input sample_t x, input sample_t thr);
    sample_t neg_thr;
    level_e  lvl;
    neg_thr = -thr;
    if (x < neg_thr)            lvl = LVL_M3;
    else if (x < sample_t'(0))  lvl = LVL_M1;
    else if (x < thr)           lvl = LVL_P1;
    else                        lvl = LVL_P3;
    return lvl;
  endfunction

  // ---------------------------------------------------------------------
  // Phase counter and sample selection
  // ---------------------------------------------------------------------
  logic [PH_W-1:0] ph_q, ph_d;
  logic            keep;

  assign keep = en && (ph_q == sym_phase);

  // Advance the in-symbol sample index on each valid sample.
  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ph_d = ph_q;
    if (en) ph_d = (ph_q == PH_W'(SPS - 1)) ? '0 : ph_q + PH_W'(1);
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (rst) ph_q <= '0;
    else     ph_q <= ph_d;
  end

  // ---------------------------------------------------------------------
  // Two-stage decision pipeline
  // ---------------------------------------------------------------------
  level_e                  lvl_i_q, lvl_q_q;
  logic                    s1_vld_q;
  logic [BITS_PER_SYM-1:0] bits_q;
  logic                    vld_q;

  // Stage 1: slice both axes of the kept sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      lvl_i_q  <= LVL_M3;
      lvl_q_q  <= LVL_M3;
    end else begin
      s1_vld_q <= keep;
      if (keep) begin
        lvl_i_q <= slice_axis(rx_I, thresh);
        lvl_q_q <= slice_axis(rx_Q, thresh);
      end
    end
  end

  // Stage 2: Gray-decode the levels and present the decided bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      bits_q <= '0;
    end else begin
      vld_q <= s1_vld_q;
      if (s1_vld_q) bits_q <= {level_to_gray(lvl_i_q), level_to_gray(lvl_q_q)};
    end
  end

  // ---------------------------------------------------------------------
  // Reference FIFO: pushed by the TX bit source, popped per decision
  // ---------------------------------------------------------------------
  logic [BITS_PER_SYM-1:0] fifo_rd;
  logic                    fifo_full;
  logic                    fifo_empty;

  sync_fifo #(
    .WIDTH (BITS_PER_SYM),
    .DEPTH (REF_DEPTH)
  ) u_ref_fifo (
    .clk         (clk),
    .rst_i       (rst),
    .push_i      (ref_valid),
    .push_data_i (ref_bits),
    .pop_i       (vld_q),
    .pop_data_o  (fifo_rd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]        sym_q, sym_d;
  logic [CNT_W-1:0]        err_q, err_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic [WARM_W-1:0]       warm_q, warm_d;
  logic [BITS_PER_SYM-1:0] err_bits;
  logic [PC_W-1:0]         err_pop;
  logic [CNT_W:0]          err_sum;
  logic                    warm_done;
  logic                    upd;
  logic                    ovf_set;
  logic                    unf_set;

  assign warm_done = (warm_q == WARM_W'(WARMUP_SYMS));
  assign upd       = vld_q && !fifo_empty && warm_done;
  // A pop on a full FIFO always frees a slot, so only a pop-less push drops.
  assign ovf_set   = ref_valid && fifo_full && !vld_q;
  assign unf_set   = vld_q && fifo_empty;
  assign err_bits  = bits_q ^ fifo_rd;
  assign err_sum   = {1'b0, err_q} + (CNT_W+1)'(err_pop);

  // Count differing bits between the decision and its reference.
  always_comb begin
    err_pop = '0;
    for (int b = 0; b < BITS_PER_SYM; b++) err_pop = err_pop + PC_W'(err_bits[b]);
  end

  // Next-state for counters, sticky flags and warm-up; clear has priority.
  always_comb begin
    sym_d  = sym_q;
    err_d  = err_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    warm_d = warm_q;
    if (clr_stats) begin
      sym_d  = '0;
      err_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      warm_d = '0;
    end else begin
      if (ovf_set) ovf_d = 1'b1;
      if (unf_set) unf_d = 1'b1;
      if (vld_q && !warm_done) warm_d = warm_q + WARM_W'(1);
      if (upd) begin
        sym_d = (sym_q == '1) ? sym_q : sym_q + CNT_W'(1);
        err_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q  <= '0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      warm_q <= '0;
    end else begin
      sym_q  <= sym_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      warm_q <= warm_d;
    end
  end

  assign bits_out    = bits_q;
  assign valid       = vld_q;
  assign bit_err_cnt = err_q;
  assign sym_cnt     = sym_q;
  assign ref_ovf     = ovf_q;
  assign ref_unf     = unf_q;

endmodule

// File: tb/tb_qam16_demapper.sv
// Scoreboard bench for qam16_demapper: stimulus pushes expected decisions,
// a negedge monitor pops and compares them whenever valid is seen.
`timescale 1ns/1ps
module tb_qam16_demapper;

  import gdsp_pkg::*;

  localparam int SPS_T   = 4;
  localparam int CNT_W_T = 10;
  localparam int WARM_T  = 16;
  localparam int DEPTH_T = 32;
  localparam logic [CNT_W_T-1:0] ALL_ONES = '1;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  sample_t            rx_i;
  sample_t            rx_q;
  logic [1:0]         sym_phase;
  sample_t            thresh;
  logic [3:0]         ref_bits;
  logic               ref_valid;
  logic               clr_stats;
  logic [3:0]         bits_out;
  logic               valid;
  logic [CNT_W_T-1:0] bit_err_cnt;
  logic [CNT_W_T-1:0] sym_cnt;
  logic               ref_ovf;
  logic               ref_unf;

  qam16_demapper #(
    .SPS         (SPS_T),
    .REF_DEPTH   (DEPTH_T),
    .WARMUP_SYMS (WARM_T),
    .CNT_W       (CNT_W_T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rx_I        (rx_i),
    .rx_Q        (rx_q),
    .sym_phase   (sym_phase),
    .thresh      (thresh),
    .ref_bits    (ref_bits),
    .ref_valid   (ref_valid),
    .clr_stats   (clr_stats),
    .bits_out    (bits_out),
    .valid       (valid),
    .bit_err_cnt (bit_err_cnt),
    .sym_cnt     (sym_cnt),
    .ref_ovf     (ref_ovf),
    .ref_unf     (ref_unf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [3:0] bits;
    int         due;
  } exp_t;

  exp_t sb[$];

  // Monitor: compare every presented decision against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("valid_missing_at_due", 64'(sb[0].due), 64'(cyc));
        void'(sb.pop_front());
      end
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bits_out", bits_out, e.bits);
          check("valid_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Watchdog bound on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  sample_t fill = '0;

  function automatic sample_t amp(input logic [1:0] g);
    sample_t a;
    case (g)
      2'b00:   a = -12'sd768;
      2'b01:   a = -12'sd256;
      2'b11:   a = 12'sd256;
      default: a = 12'sd768;
    endcase
    return a;
  endfunction

  function automatic sample_t noisy(input logic [1:0] g);
    return amp(g) + sample_t'($urandom_range(0, 400)) - sample_t'(200);
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      en = 1'b0; ref_valid = 1'b0; clr_stats = 1'b0; rx_i = '0; rx_q = '0;
    end
  endtask

  // One symbol period of SPS back-to-back samples; the one at sym_phase is real.
  task automatic send_sym(input sample_t i, input sample_t q, input logic [3:0] exp_bits,
                          input logic [3:0] rb, input bit push, input int clr_pos);
    for (int k = 0; k < SPS_T; k++) begin
      @(posedge clk); #1;
      en        = 1'b1;
      rx_i      = (k == int'(sym_phase)) ? i : fill;
      rx_q      = (k == int'(sym_phase)) ? q : fill;
      ref_valid = (k == int'(sym_phase)) && push;
      ref_bits  = rb;
      clr_stats = (k == clr_pos);
      if (k == int'(sym_phase)) sb.push_back('{exp_bits, cyc + 2});
    end
  endtask

  task automatic send_bits(input logic [3:0] b, input logic [3:0] rb, input bit push);
    send_sym(noisy(b[3:2]), noisy(b[1:0]), b, rb, push, -1);
  endtask

  task automatic pulse_clr();
    idle(4);
    @(posedge clk); #1; clr_stats = 1'b1;
    @(posedge clk); #1; clr_stats = 1'b0;
  endtask

  task automatic push_ref(input logic [3:0] v);
    @(posedge clk); #1;
    en = 1'b0; clr_stats = 1'b0; ref_valid = 1'b1; ref_bits = v;
  endtask

  int         bnd_val [6] = '{-513, -512, -1, 0, 511, 512};
  logic [1:0] bnd_exp [6] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};

  initial begin
    logic [3:0] b;
    logic [3:0] rb;

    rst = 1'b1; en = 1'b0; rx_i = '0; rx_q = '0; sym_phase = 2'd0;
    thresh = QAM_THRESH_DEF; ref_bits = '0; ref_valid = 1'b0; clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_bits_out", bits_out, 0);
    check("reset_bit_err_cnt", bit_err_cnt, 0);
    check("reset_sym_cnt", sym_cnt, 0);
    check("reset_ref_ovf", ref_ovf, 0);
    check("reset_ref_unf", ref_unf, 0);

    // Ideal symbol, zeros on the other samples: I=+3 -> 10, Q=-1 -> 01.
    send_sym(12'sd768, -12'sd256, 4'b1001, 4'b1001, 1'b1, -1);
    send_sym(12'sd768, -12'sd256, 4'b1001, 4'b1001, 1'b1, -1);
    fill = -12'sd1500;

    // Slicer boundaries on I (Q=300 -> 11), phase 0.
    for (int k = 0; k < 6; k++)
      send_sym(sample_t'(bnd_val[k]), 12'sd300, {bnd_exp[k], 2'b11}, {bnd_exp[k], 2'b11}, 1'b1, -1);
    // Slicer boundaries on Q (I=-600 -> 00), phase moved to 2.
    sym_phase = 2'd2;
    for (int k = 0; k < 6; k++)
      send_sym(-12'sd600, sample_t'(bnd_val[k]), {2'b00, bnd_exp[k]}, {2'b00, bnd_exp[k]}, 1'b1, -1);
    sym_phase = 2'd0;

    // Noise-free-decision loopback of 1000 symbols after a stats clear.
    pulse_clr();
    for (int j = 0; j < 1000; j++) begin
      b = 4'($urandom_range(0, 15));
      send_bits(b, b, 1'b1);
    end
    idle(4);
    @(negedge clk);
    check("loop_sym_cnt", sym_cnt, 984);
    check("loop_bit_err_cnt", bit_err_cnt, 0);
    check("loop_ref_ovf", ref_ovf, 0);
    check("loop_ref_unf", ref_unf, 0);

    // One flipped reference bit every 10 compared symbols.
    pulse_clr();
    for (int j = 0; j < WARM_T + 200; j++) begin
      b  = 4'($urandom_range(0, 15));
      rb = b;
      if (j >= WARM_T && (j - WARM_T) % 10 == 0) rb = b ^ (4'd1 << ((j - WARM_T) / 10 % 4));
      send_bits(b, rb, 1'b1);
    end
    idle(4);
    @(negedge clk);
    check("inject_sym_cnt", sym_cnt, 200);
    check("inject_bit_err_cnt", bit_err_cnt, 20);

    // clr_stats in the very cycle the counters would update.
    send_sym(12'sd768, 12'sd768, 4'b1010, 4'b0101, 1'b1, 2);
    @(negedge clk);
    check("clr_win_sym_cnt", sym_cnt, 0);
    check("clr_win_bit_err_cnt", bit_err_cnt, 0);
    idle(4);

    // Warm up again, then overflow the reference FIFO with 33 entries.
    for (int j = 0; j < WARM_T; j++) begin
      b = 4'($urandom_range(0, 15));
      send_bits(b, b, 1'b1);
    end
    idle(4);
    @(negedge clk);
    check("pre_ovf_ref_ovf", ref_ovf, 0);
    for (int k = 0; k < DEPTH_T + 1; k++) push_ref(4'(k));
    idle(1);
    @(negedge clk);
    check("ovf_ref_ovf", ref_ovf, 1);
    // The 32 retained entries must be the first 32 pushed, in order.
    for (int k = 0; k < DEPTH_T; k++) send_bits(4'(k), 4'h0, 1'b0);
    idle(4);
    @(negedge clk);
    check("retained_sym_cnt", sym_cnt, DEPTH_T);
    check("retained_bit_err_cnt", bit_err_cnt, 0);
    check("retained_ref_unf", ref_unf, 0);
    // One decision on an empty FIFO.
    send_bits(4'b0110, 4'h0, 1'b0);
    idle(4);
    @(negedge clk);
    check("unf_ref_unf", ref_unf, 1);
    check("unf_sym_cnt", sym_cnt, DEPTH_T);
    check("unf_ref_ovf_sticky", ref_ovf, 1);

    // Saturation: every symbol compares with all four bits wrong.
    pulse_clr();
    @(negedge clk);
    check("clr_ref_ovf", ref_ovf, 0);
    check("clr_ref_unf", ref_unf, 0);
    for (int j = 0; j < WARM_T + 1023; j++) begin
      b = 4'($urandom_range(0, 15));
      send_bits(b, b ^ 4'hF, 1'b1);
    end
    idle(4);
    @(negedge clk);
    check("sat_sym_cnt_full", sym_cnt, ALL_ONES);
    check("sat_bit_err_cnt", bit_err_cnt, ALL_ONES);
    send_bits(4'b1111, 4'b0000, 1'b1);
    idle(4);
    @(negedge clk);
    check("sat_sym_cnt_hold", sym_cnt, ALL_ONES);
    check("sat_bit_err_hold", bit_err_cnt, ALL_ONES);

    // Reset in mid-stream with the FIFO occupied and a symbol in flight.
    push_ref(4'h3);
    push_ref(4'h5);
    @(posedge clk); #1;
    en = 1'b1; ref_valid = 1'b1; ref_bits = 4'hA; rx_i = 12'sd768; rx_q = 12'sd768;
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; ref_valid = 1'b0; rx_i = '0; rx_q = '0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", valid, 0);
    check("midrst_bits_out", bits_out, 0);
    check("midrst_sym_cnt", sym_cnt, 0);
    check("midrst_bit_err_cnt", bit_err_cnt, 0);
    check("midrst_ref_ovf", ref_ovf, 0);
    check("midrst_ref_unf", ref_unf, 0);
    // FIFO must be empty: a decision without a push underflows.
    send_bits(4'b1100, 4'h0, 1'b0);
    idle(4);
    @(negedge clk);
    check("midrst_fifo_empty_unf", ref_unf, 1);
    check("midrst_post_sym_cnt", sym_cnt, 0);

    idle(2);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
